// File: rtl/prod_accum.sv
// Frame accumulator for a signed product stream: sums N products per frame with saturation
// and presents each frame result through a valid/ready output register.
module prod_accum #(
    parameter int unsigned PW = 8,
    parameter int unsigned AW = 16,
    parameter int unsigned N  = 4,
    localparam int unsigned CW = $clog2(N)
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_valid,
    input  logic [PW-1:0] y,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] sum,
    output logic          ovf,
    output logic [CW-1:0] cnt
);

    localparam logic [CW-1:0] LastCnt = CW'(N - 1);
    localparam logic [AW-1:0] SatMax  = {1'b0, {(AW - 1){1'b1}}};
    localparam logic [AW-1:0] SatMin  = {1'b1, {(AW - 1){1'b0}}};

    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          acc_ovf_q, acc_ovf_d;
    logic          out_valid_q, out_valid_d;
    logic [AW-1:0] sum_q, sum_d;
    logic          ovf_q, ovf_d;

    logic          last;
    logic          accept;
    logic [AW:0]   acc_ext;
    logic [AW:0]   y_ext;
    logic [AW:0]   add_ext;
    logic [AW-1:0] sat_val;
    logic          new_ovf;

    assign last     = (cnt_q == LastCnt);
    // Stall only the frame-closing product while the previous result is still held.
    assign in_ready = !(last && out_valid_q && !out_ready);
    assign accept   = in_valid && in_ready && !clr;

    // One guard bit above the accumulator exposes overflow as a sign-bit disagreement.
    assign acc_ext = {acc_q[AW-1], acc_q};
    assign y_ext   = {{(AW + 1 - PW){y[PW-1]}}, y};
    assign add_ext = acc_ext + y_ext;

    always_comb begin
        new_ovf = 1'b0;
        sat_val = add_ext[AW-1:0];
        if (add_ext[AW] != add_ext[AW-1]) begin
            new_ovf = 1'b1;
            sat_val = add_ext[AW] ? SatMin : SatMax;
        end
    end

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        acc_ovf_d   = acc_ovf_q;
        sum_d       = sum_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (clr) begin
            acc_d     = '0;
            cnt_d     = '0;
            acc_ovf_d = 1'b0;
        end else if (accept) begin
            if (last) begin
                sum_d       = sat_val;
                ovf_d       = acc_ovf_q | new_ovf;
                out_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
                acc_ovf_d   = 1'b0;
            end else begin
                acc_d     = sat_val;
                cnt_d     = cnt_q + CW'(1);
                acc_ovf_d = acc_ovf_q | new_ovf;
            end
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            acc_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            acc_ovf_q   <= acc_ovf_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign ovf       = ovf_q;
    assign cnt       = cnt_q;

endmodule

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum: default 16-bit instance plus an 8-bit instance for saturation.
module tb_prod_accum;

    logic       clk1 = 1'b0;
    logic       rst_n;

    logic       clr, in_valid, out_ready;
    logic [7:0] y;
    logic       in_ready, out_valid, ovf;
    logic [15:0] sum;
    logic [1:0] cnt;

    logic       clr8, in_valid8, out_ready8;
    logic [7:0] y8;
    logic       in_ready8, out_valid8, ovf8;
    logic [7:0] sum8;
    logic [1:0] cnt8;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk1 = ~clk1;

    prod_accum #(.PW(8), .AW(16), .N(4)) u_dut (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .y         (y),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .ovf       (ovf),
        .cnt       (cnt)
    );

    prod_accum #(.PW(8), .AW(8), .N(4)) u_dut8 (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .clr       (clr8),
        .in_valid  (in_valid8),
        .y         (y8),
        .in_ready  (in_ready8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .sum       (sum8),
        .ovf       (ovf8),
        .cnt       (cnt8)
    );

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic push(input int v);
        in_valid = 1'b1;
        y        = 8'(v);
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic push8(input int v);
        in_valid8 = 1'b1;
        y8        = 8'(v);
        tick();
    endtask

    int bub_y[7]   = '{-6, 0, 49, 0, 0, 16, 0};
    bit bub_v[7]   = '{1, 0, 1, 0, 0, 1, 1};
    int bub_cnt[7] = '{1, 1, 2, 2, 2, 3, 0};

    initial begin
        rst_n = 1'b0;
        clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1; y = '0;
        clr8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b1; y8 = '0;
        #12;
        check("rst out_valid", int'(out_valid), 0);
        check("rst sum", int'($signed(sum)), 0);
        check("rst cnt", int'(cnt), 0);
        check("rst ovf", int'(ovf), 0);
        @(negedge clk1);
        rst_n = 1'b1;
        tick();

        // Basic frame
        push(-8); push(-56); push(16);
        check("basic cnt3", int'(cnt), 3);
        push(-20);
        check("basic valid", int'(out_valid), 1);
        check("basic sum", int'($signed(sum)), -68);
        check("basic ovf", int'(ovf), 0);
        idle();
        check("basic drop", int'(out_valid), 0);
        check("basic hold", int'($signed(sum)), -68);

        // Bubbles
        for (int i = 0; i < 7; i++) begin
            in_valid = bub_v[i];
            y        = 8'(bub_y[i]);
            tick();
            check($sformatf("bubble cnt%0d", i), int'(cnt), bub_cnt[i]);
        end
        check("bubble valid", int'(out_valid), 1);
        check("bubble sum", int'($signed(sum)), 59);
        check("bubble ovf", int'(ovf), 0);
        idle();

        // Backpressure
        out_ready = 1'b0;
        push(16); push(16); push(16); push(16);
        check("bp A valid", int'(out_valid), 1);
        check("bp A sum", int'($signed(sum)), 64);
        push(49); push(49); push(49);
        check("bp B cnt", int'(cnt), 3);
        in_valid = 1'b1; y = 8'd49;
        #1;
        check("bp stall", int'(in_ready), 0);
        tick(); tick();
        check("bp hold sum", int'($signed(sum)), 64);
        check("bp hold valid", int'(out_valid), 1);
        check("bp hold cnt", int'(cnt), 3);
        out_ready = 1'b1;
        #1;
        check("bp release", int'(in_ready), 1);
        tick();
        check("bp B valid", int'(out_valid), 1);
        check("bp B sum", int'($signed(sum)), 196);
        check("bp B cnt", int'(cnt), 0);
        idle();
        check("bp drain", int'(out_valid), 0);

        // Saturation on the 8-bit accumulator
        push8(100); push8(100); push8(-56); push8(1);
        in_valid8 = 1'b0;
        check("sat valid", int'(out_valid8), 1);
        check("sat sum", int'($signed(sum8)), 72);
        check("sat ovf", int'(ovf8), 1);
        push8(1); push8(1); push8(1); push8(1);
        in_valid8 = 1'b0;
        check("sat2 sum", int'($signed(sum8)), 4);
        check("sat2 ovf", int'(ovf8), 0);

        // Flush
        push(4); push(4);
        check("clr pre cnt", int'(cnt), 2);
        clr = 1'b1;
        push(7);
        clr = 1'b0;
        check("clr cnt", int'(cnt), 0);
        check("clr no out", int'(out_valid), 0);
        push(1); push(1); push(1); push(1);
        check("clr sum", int'($signed(sum)), 4);
        check("clr valid", int'(out_valid), 1);
        idle();

        // Async reset with a pending result
        out_ready = 1'b0;
        push(3); push(3); push(3); push(3);
        push(5);
        in_valid = 1'b0;
        check("prerst valid", int'(out_valid), 1);
        check("prerst cnt", int'(cnt), 1);
        @(negedge clk1);
        rst_n = 1'b0;
        #1;
        check("async valid", int'(out_valid), 0);
        check("async sum", int'($signed(sum)), 0);
        check("async cnt", int'(cnt), 0);
        @(negedge clk1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        push(2); push(2); push(2); push(2);
        check("postrst sum", int'($signed(sum)), 8);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/prod_accum.md
Name: prod_accum

Overview:
- Downstream consumer of the 4x4 signed pipelined multiplier: takes its 8-bit signed product stream and sums N consecutive products per frame (dot-product / MAC back end).
- Presents one saturated signed sum per frame through a valid/ready output register with backpressure.
- Runs on a single clock, clk1.

Parameters:
- PW, 8, product width (signed two's complement).
- AW, 16, accumulator and result width; must be >= PW.
- N, 4, products per frame; must be >= 2.

Ports:
- clk1  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous flush of the partial frame.
- in_valid  input  1  product present on y.
- y  input  PW  signed product from the multiplier.
- in_ready  output  1  product accepted this cycle when in_valid && in_ready.
- out_valid  output  1  sum and ovf hold a completed frame.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  AW  signed frame sum, saturated.
- ovf  output  1  a saturation event occurred in this frame.
- cnt  output  clog2(N)  number of products accepted in the current partial frame.

Behaviour:
- Reset (async, rst_n=0): acc=0, cnt=0, acc_ovf=0, out_valid=0, sum=0, ovf=0. Release is synchronous to clk1; the first accept is possible on the first edge after release.
- Sign extension: y is sign-extended to AW+1 bits before each add.
- Saturation:
  - Result > 2^(AW-1)-1: clamp to 2^(AW-1)-1 and set acc_ovf.
  - Result < -2^(AW-1): clamp to -2^(AW-1) and set acc_ovf.
  - Accumulation continues from the clamped value.
- in_ready is combinational: in_ready = !(cnt==N-1 && out_valid && !out_ready). It stalls only when the final product of a frame arrives while the previous result is still unconsumed.
- Accept with cnt < N-1: acc <= sat(acc + y), cnt <= cnt+1, acc_ovf <= acc_ovf | new_ovf.
- Accept with cnt == N-1 (frame complete):
  - sum <= sat(acc + y); ovf <= acc_ovf | new_ovf; out_valid <= 1.
  - acc <= 0, cnt <= 0, acc_ovf <= 0.
- Latency: sum/out_valid are visible 1 cycle after the edge that accepts the Nth product.
- Output handshake:
  - out_valid && out_ready with no new completion: out_valid <= 0 next edge; sum/ovf hold their last value.
  - Completion and consumption in the same edge: the new result replaces the old one and out_valid stays 1, so back-to-back frames run with no bubble.
- Output stability: sum/ovf must not change while out_valid=1 && out_ready=0.
- clr=1:
  - acc, cnt, acc_ovf are cleared; any product presented that cycle is dropped.
  - The output register and out_valid are unaffected.
  - clr has priority over accept.
- Mid-frame rst_n assertion clears everything immediately, including a pending result; no partial sum is emitted.
- in_valid=0 cycles inside a frame (pipeline bubbles) leave acc/cnt unchanged.

Test Plan:
- Basic frame: N=4, out_ready=1; products -8, -56, 16, -20 on consecutive cycles -> one cycle after the 4th, out_valid=1, sum=-68 (0xFFBC), ovf=0; out_valid drops the next cycle.
- Bubbles: products -6, idle, 49, idle, idle, 16, 0 -> sum=59, ovf=0; cnt steps 1, 1, 2, 2, 2, 3, 0.
- Backpressure: out_ready=0; frame A = 4x16 gives sum=64; frame B = 49, 49, 49 are accepted, 4th product 49 sees in_ready=0.
  - sum=64 stays stable until out_ready=1.
  - In the cycle out_ready=1, 49 is accepted; next cycle sum=196.
- Saturation: AW=8 override; products 100, 100, -56, 1 -> clamp at 127 after the 2nd, then 71, then 72; sum=72, ovf=1. Next frame 1, 1, 1, 1 -> sum=4, ovf=0.
- clr / reset: 2 products (4, 4) then clr=1 with in_valid=1, y=7 -> cnt=0 and 7 is dropped; next 4 products of 1 give sum=4.
  - Separately, rst_n=0 mid-frame with out_valid=1 -> out_valid=0 and sum=0 immediately, without waiting for a clock edge.
